// File: rtl/wvl_lag_ch_capture.sv
// wvl_lag_ch_capture: measures sync-to-sample lag for one selected channel and packs it for check_lag_data_ch.
// Optional LAG_CAPTURE_AUTO_REARM_EN: re-arm from DONE every frame while arm stays high.
module wvl_lag_ch_capture #(
  parameter int CH_W   = 8,
  parameter int DATA_W = 16,
  parameter int LAG_W  = 12
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic              sync_in,
  input  logic              data_valid,
  input  logic [CH_W-1:0]   ch_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CH_W-1:0]   sel_ch,
  input  logic              arm,
  output logic              busy,
  output logic [31:0]       lag_data_ch
);
  typedef enum logic [1:0] {IDLE, WAIT_SYNC, SEARCH, DONE} state_t;
  state_t state, state_nx;
  logic arm_d, arm_edge, hit, capture, tmo, resync, start, rearm, busy_nx, resync_q;
  logic [CH_W-1:0] sel_q;
  logic [LAG_W-1:0] lag_cnt, lag_now;
  logic [31:0] word_nx;
`ifdef LAG_CAPTURE_AUTO_REARM_EN
  assign rearm = arm;
`else
  assign rearm = 1'b0;
`endif
  // arm_d resets high so a level already asserted at release is not an edge
  assign arm_edge = arm & ~arm_d;
  assign hit      = data_valid && ch_in == sel_q;
  assign lag_now  = state == WAIT_SYNC ? '0 : lag_cnt;
  assign capture  = !arm_edge && hit && ((state == WAIT_SYNC && sync_in) || state == SEARCH);
  assign resync   = !arm_edge && state == SEARCH && sync_in && !hit;
  assign tmo      = !arm_edge && state == SEARCH && !hit && !sync_in && &lag_cnt;
  assign start    = !arm_edge && ((state == WAIT_SYNC && sync_in) || resync);
  always_ff @(posedge user_clk or negedge user_rst_n)
    if (!user_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = arm_edge ? WAIT_SYNC :
               state == WAIT_SYNC && sync_in ? (hit ? DONE : SEARCH) :
               state == SEARCH && (capture || tmo) ? DONE :
               state == DONE && rearm ? WAIT_SYNC : state;
  end
  always_comb begin
    busy_nx = state_nx == WAIT_SYNC || state_nx == SEARCH;
    word_nx = arm_edge ? {3'b000, lag_data_ch[28:0]} :
              capture ? {1'b1, 1'b0, resync_q, 13'(lag_now), 16'(data_in)} :
              tmo ? {1'b1, 1'b1, resync_q, 13'({LAG_W{1'b1}}), 16'h0000} : lag_data_ch;
  end
  always_ff @(posedge user_clk or negedge user_rst_n)
    if (!user_rst_n) begin
      arm_d       <= 1'b1;
      sel_q       <= '0;
      lag_cnt     <= '0;
      resync_q    <= 1'b0;
      busy        <= 1'b0;
      lag_data_ch <= '0;
    end else begin
      arm_d       <= arm;
      busy        <= busy_nx;
      lag_data_ch <= word_nx;
      sel_q       <= arm_edge ? sel_ch : sel_q;
      lag_cnt     <= arm_edge ? '0 : start ? LAG_W'(1) : state == SEARCH ? lag_cnt + LAG_W'(1) : lag_cnt;
      resync_q    <= state_nx == WAIT_SYNC ? 1'b0 : resync | resync_q;
    end
endmodule

// File: tb/tb_wvl_lag_ch_capture.sv
// tb_wvl_lag_ch_capture: directed and random stimulus against a timestamp-based reference model.
module tb_wvl_lag_ch_capture;
  logic user_clk = 1'b0, user_rst_n = 1'b0;
  logic sync_in = 1'b0, data_valid = 1'b0, arm = 1'b0, busy;
  logic [7:0] ch_in = '0, sel_ch = '0;
  logic [15:0] data_in = '0;
  logic [31:0] lag_data_ch;
  int n_chk = 0, n_fail = 0;
  int cyc, sync_cyc, m_state;
  bit m_rs, m_arm_d, m_busy;
  logic [7:0] m_sel;
  logic [31:0] m_word;
  wvl_lag_ch_capture dut (
    .user_clk(user_clk), .user_rst_n(user_rst_n), .sync_in(sync_in), .data_valid(data_valid),
    .ch_in(ch_in), .data_in(data_in), .sel_ch(sel_ch), .arm(arm), .busy(busy), .lag_data_ch(lag_data_ch)
  );
  always #5 user_clk = ~user_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    cyc = 0; sync_cyc = 0; m_state = 0; m_rs = 0; m_arm_d = 1; m_busy = 0; m_sel = '0; m_word = '0;
  endtask
  // states: 0 idle, 1 waiting for sync, 2 searching, 3 done; lag is clocks since the last sync
  task automatic m_step();
    int lag;
    bit hit;
    lag = m_state == 1 ? 0 : cyc - sync_cyc;
    hit = data_valid && ch_in == m_sel;
    if (arm && !m_arm_d) begin
      m_sel = sel_ch; m_word[31:29] = 3'b000; m_state = 1; m_rs = 0;
    end else if (m_state == 1 && sync_in) begin
      if (hit) begin m_word = {1'b1, 1'b0, 1'b0, 13'(lag), data_in}; m_state = 3; end
      else begin m_state = 2; sync_cyc = cyc; end
    end else if (m_state == 2) begin
      if (hit) begin m_word = {1'b1, 1'b0, m_rs, 13'(lag), data_in}; m_state = 3; end
      else if (sync_in) begin m_rs = 1; sync_cyc = cyc; end
      else if (lag == 4095) begin m_word = {1'b1, 1'b1, m_rs, 13'h0FFF, 16'h0}; m_state = 3; end
    end else if (m_state == 3) begin
`ifdef LAG_CAPTURE_AUTO_REARM_EN
      if (arm) begin m_state = 1; m_rs = 0; end
`endif
    end
    m_arm_d = arm;
    m_busy = m_state == 1 || m_state == 2;
    cyc++;
  endtask
  task automatic step(input bit s, input bit v, input logic [7:0] c, input logic [15:0] d, input bit a, input logic [7:0] sel);
    sync_in = s; data_valid = v; ch_in = c; data_in = d; arm = a; sel_ch = sel;
    m_step();
    @(negedge user_clk);
    chk("word", lag_data_ch, m_word);
    chk("busy", 32'(busy), 32'(m_busy));
  endtask
  task automatic idle(input int n, input logic [7:0] sel);
    for (int i = 0; i < n; i++) step(0, 0, 8'd0, 16'h0, arm, sel);
  endtask
  task automatic arm_on(input logic [7:0] sel);
    step(0, 0, 8'd0, 16'h0, 0, sel);
    step(0, 0, 8'd0, 16'h0, 1, sel);
  endtask
  initial begin
    m_reset();
    repeat (2) @(negedge user_clk);
    chk("rst_word", lag_data_ch, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    user_rst_n = 1'b1;
    arm_on(8'd5);
    step(1, 0, 8'd0, 16'h0, 1, 8'd5);
    idle(6, 8'd5);
    step(0, 1, 8'd5, 16'h1234, 1, 8'd5);
    chk("t1_lag7", lag_data_ch, 32'h8007_1234);
`ifndef LAG_CAPTURE_AUTO_REARM_EN
    chk("t1_busy", 32'(busy), 32'h0);
`endif
    arm_on(8'd5);
    step(1, 1, 8'd5, 16'hABCD, 1, 8'd5);
    chk("t2_lag0", lag_data_ch, 32'h8000_ABCD);
    arm_on(8'd5);
    step(1, 0, 8'd0, 16'h0, 1, 8'd5);
    for (int i = 0; i < 4095; i++) step(0, 1, 8'd6, 16'hFFFF, 1, 8'd5);
    chk("t3_timeout", lag_data_ch, 32'hCFFF_0000);
    arm_on(8'd5);
    step(1, 0, 8'd0, 16'h0, 1, 8'd5);
    idle(2, 8'd5);
    step(1, 0, 8'd0, 16'h0, 1, 8'd5);
    idle(6, 8'd5);
    step(0, 1, 8'd5, 16'h5555, 1, 8'd5);
    chk("t4_resync", lag_data_ch, 32'hA007_5555);
    arm_on(8'd5);
    step(1, 0, 8'd0, 16'h0, 1, 8'd5);
    idle(3, 8'd9);
    step(0, 1, 8'd5, 16'h0042, 1, 8'd9);
    chk("t5_sel_latched", lag_data_ch, 32'h8004_0042);
    arm_on(8'd5);
    step(1, 0, 8'd0, 16'h0, 1, 8'd5);
    idle(2, 8'd5);
    arm_on(8'd5);
    chk("t5_rearm_clr", lag_data_ch, 32'h0004_0042);
    chk("t5_rearm_busy", 32'(busy), 32'h1);
    step(0, 1, 8'd5, 16'h7777, 1, 8'd5);
    chk("t5_no_capture", lag_data_ch, 32'h0004_0042);
    step(1, 0, 8'd0, 16'h0, 1, 8'd5);
    idle(2, 8'd5);
    #2 user_rst_n = 1'b0;
    #1;
    chk("t6_async_word", lag_data_ch, 32'h0);
    chk("t6_async_busy", 32'(busy), 32'h0);
    m_reset();
    @(negedge user_clk);
    user_rst_n = 1'b1;
`ifdef LAG_CAPTURE_AUTO_REARM_EN
    arm_on(8'd3);
    step(1, 0, 8'd0, 16'h0, 1, 8'd3);
    idle(6, 8'd3);
    step(0, 1, 8'd3, 16'h1111, 1, 8'd3);
    chk("auto_f1", lag_data_ch, 32'h8007_1111);
    idle(1, 8'd3);
    step(1, 0, 8'd0, 16'h0, 1, 8'd3);
    idle(8, 8'd3);
    step(0, 1, 8'd3, 16'h2222, 1, 8'd3);
    chk("auto_f2", lag_data_ch, 32'h8009_2222);
`endif
    for (int i = 0; i < 3000; i++) begin
      bit a;
      a = ($urandom_range(0, 39) == 0) ? ~arm : arm;
      step($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)),
           16'($urandom), a, 8'($urandom_range(0, 7)));
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
